// File: rtl/priority_irq_ctrl.sv
// priority_irq_ctrl: edge-captured sticky pending requests presented highest-index-first over valid/ack.
// Optional PRIORITY_IRQ_MASK_EN adds a per-line selection mask (1 = disabled).
module priority_irq_ctrl #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
`ifdef PRIORITY_IRQ_MASK_EN
    input  logic [N-1:0] mask,
`endif
    output logic [W-1:0] irq_id,
    output logic         irq_valid,
    output logic [N-1:0] pending,
    output logic         overrun
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state;
    logic [N-1:0] req_q, rise, clr, sel;
    logic [W-1:0] enc;
    assign rise = req & ~req_q;
    assign clr = (state == PRESENT && ack) ? N'(1) << irq_id : '0;
`ifdef PRIORITY_IRQ_MASK_EN
    assign sel = pending & ~mask;
`else
    assign sel = pending;
`endif
    // ascending scan, so the highest set index is what remains
    always_comb begin
        enc = '0;
        for (int i = 0; i < N; i++)
            if (sel[i]) enc = W'(i);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= '0;
            pending   <= '0;
            irq_id    <= '0;
            irq_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            req_q   <= req;
            pending <= (pending & ~clr) | rise;
            overrun <= |(rise & pending & ~clr);
            if (state == IDLE) begin
                if (|sel) begin
                    irq_id    <= enc;
                    irq_valid <= 1'b1;
                    state     <= PRESENT;
                end
            end else if (ack) begin
                irq_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_priority_irq_ctrl.sv
// tb_priority_irq_ctrl: directed and random stimulus against a bit-level behavioural model.
module tb_priority_irq_ctrl;
    localparam int N = 8;
    localparam int W = $clog2(N);
    logic clk = 0, rst = 1, ack = 0;
    logic [N-1:0] req = '0;
    logic [W-1:0] irq_id;
    logic irq_valid, overrun;
    logic [N-1:0] pending;
    logic [N-1:0] msk = '0;
    int checks = 0, errors = 0;
    logic [N-1:0] m_pend, m_rq;
    int m_id;
    bit m_valid, m_ovr;

    priority_irq_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
`ifdef PRIORITY_IRQ_MASK_EN
        .mask(msk),
`endif
        .irq_id(irq_id), .irq_valid(irq_valid), .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_rq = '0; m_id = 0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic check_model();
        check("valid", 32'(irq_valid), 32'(m_valid));
        check("id", 32'(irq_id), 32'(m_id));
        check("pending", 32'(pending), 32'(m_pend));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // one clock: apply inputs, advance the reference by the behavioural rules, compare
    task automatic step(input logic [N-1:0] r, input logic a);
        int c, h;
        bit rs, ov;
        logic [N-1:0] np;
        req = r; ack = a;
        @(posedge clk);
        c = (m_valid && a) ? m_id : -1;
        h = -1;
        for (int i = 0; i < N; i++) if (m_pend[i] && !msk[i]) h = i;
        ov = 0;
        for (int i = 0; i < N; i++) begin
            rs = r[i] && !m_rq[i];
            if (rs && m_pend[i] && i != c) ov = 1;
            np[i] = (m_pend[i] && i != c) || rs;
        end
        m_pend = np; m_rq = r; m_ovr = ov;
        if (m_valid) begin
            if (a) m_valid = 0;
        end else if (h >= 0) begin
            m_valid = 1; m_id = h;
        end
        #1 check_model();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_model();
        rst = 0;
        repeat (5) begin
            step('0, 0);
            check("idle_valid", 32'(irq_valid), 0);
        end
        // 0x05: grant 2, then 0 after one dead cycle
        step(8'h05, 0); check("p05", 32'(pending), 32'h05);
        step(8'h05, 0); check("g2", 32'(irq_id), 2); check("g2v", 32'(irq_valid), 1);
        step(8'h05, 1); check("dead", 32'(irq_valid), 0); check("p01", 32'(pending), 32'h01);
        step(8'h05, 0); check("g0", 32'(irq_id), 0); check("g0v", 32'(irq_valid), 1);
        step(8'h05, 1); check("p00", 32'(pending), 32'h00);
        step(8'h00, 0);
        // no preemption while presenting id 3
        step(8'h08, 0);
        step(8'h08, 0); check("g3", 32'(irq_id), 3);
        repeat (6) step(8'h88, 0);
        check("hold3", 32'(irq_id), 3); check("p88", 32'(pending), 32'h88);
        step(8'h88, 1);
        step(8'h88, 0); check("g7", 32'(irq_id), 7);
        step(8'h00, 1);
        step(8'h00, 0);
        // overrun on a re-rise of a pending, un-acked bit
        step(8'h10, 0);
        step(8'h10, 0); check("g4", 32'(irq_id), 4);
        step(8'h00, 0);
        step(8'h10, 0); check("ovr1", 32'(overrun), 1); check("p10", 32'(pending), 32'h10);
        step(8'h10, 0); check("ovr0", 32'(overrun), 0);
        // ack coinciding with a new rise keeps the bit pending, no overrun
        step(8'h00, 0);
        step(8'h10, 1); check("setwin", 32'(pending), 32'h10); check("noovr", 32'(overrun), 0);
        step(8'h10, 0); check("re4", 32'(irq_id), 4); check("re4v", 32'(irq_valid), 1);
        step(8'h00, 1);
        step(8'h00, 0);
`ifdef PRIORITY_IRQ_MASK_EN
        msk = 8'h80;
        step(8'h81, 0);
        step(8'h81, 0); check("mask_g0", 32'(irq_id), 0);
        msk = 8'h00;
        step(8'h81, 1);
        step(8'h81, 0); check("mask_g7", 32'(irq_id), 7);
        step(8'h00, 1);
        step(8'h00, 0);
`endif
        // asynchronous reset mid-presentation
        step(8'h20, 0);
        step(8'h20, 0); check("g5", 32'(irq_valid), 1);
        #2 rst = 1; req = '0; ack = 0;
        #1 model_reset();
        check_model();
        @(posedge clk); #1 rst = 0;
        check_model();
        // random traffic with sparse toggles and occasional acks
        for (int k = 0; k < 3000; k++) begin
`ifdef PRIORITY_IRQ_MASK_EN
            if ($urandom_range(0, 15) == 0) msk = N'($urandom);
`endif
            step(req ^ (N'($urandom) & N'($urandom) & N'($urandom)), $urandom_range(0, 2) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/priority_irq_ctrl.md
Name: priority_irq_ctrl

Overview:
- Parametrised, registered successor to the combinational 4-bit priority encoder.
- Captures rising edges on N request lines into sticky pending bits.
- Presents the highest-index pending request as a one-hot-free binary ID with a valid/ack handshake.
- Sits between peripheral event lines and a CPU or sequencer that services one event at a time.

Parameters:
- N, 8, number of request lines; legal range 2..32.
- W, $clog2(N), width of the ID output; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  level request lines, synchronous to clk; a 0->1 transition is an event.
- ack  input  1  consumer accepts the presented ID; sampled only while irq_valid=1.
- irq_id  output  W  index of the highest pending request being presented.
- irq_valid  output  1  irq_id is valid and held stable until ack.
- pending  output  N  registered sticky pending bits, for status readback.
- overrun  output  1  one-cycle pulse: an event arrived on a bit that was already pending.

Behaviour:
- Reset (asynchronous, rst=1):
  - pending=0, req_q=0, irq_id=0, irq_valid=0, overrun=0, state=IDLE.
  - req_q resets to 0, so a line already high when reset releases counts as an event at the first edge.
- Edge detect:
  - rise = req & ~req_q, evaluated combinationally.
  - req_q <= req every cycle.
- Pending update every edge: pending <= (pending & ~clr) | rise.
  - clr is one-hot of irq_id when (state==PRESENT && ack), else 0.
  - If a rise and a clr hit the same bit in the same cycle, the set wins and the bit stays pending.
- Overrun:
  - overrun <= |(rise & pending & ~clr).
  - Registered, so it is high for exactly the one cycle after the offending edge.
  - A bit in the middle of being cleared does not cause overrun.
- FSM, two states:
  - IDLE: irq_valid=0. If pending!=0 at a rising edge, then irq_id <= highest set index of pending, irq_valid <= 1, and the FSM moves to PRESENT.
    - Selection uses the registered pending, not that cycle's rise.
  - PRESENT: irq_id and irq_valid are held constant, and higher-priority arrivals do not preempt.
    - On ack=1: the bit is cleared as above, irq_valid <= 0, and the FSM moves to IDLE.
    - With ack=0: the FSM stays in PRESENT.
- Latency:
  - A req rise before edge E1 sets pending at E1.
  - irq_valid=1 after E2, so the ID is presented two cycles after the event.
  - If ack=1 during the cycle before E3, irq_valid=0 after E3.
  - If more requests are pending, the next ID is valid after E4: one mandatory dead cycle between grants.
- ack while irq_valid=0 is ignored, with no state change.
- Priority: index N-1 is highest and index 0 is lowest, matching the earlier encoder ordering.
- Reset asserted mid-handshake clears everything immediately; the presented ID is lost and no overrun is reported.
- Width rule: irq_id is zero-extended from the encoder result; no value >= N is ever produced.

Optional Feature:
- Macro: PRIORITY_IRQ_MASK_EN.
- Defined:
  - Adds input mask (N bits, 1 = disabled).
  - Masked bits still latch into pending and still report overrun.
  - Selection in IDLE uses pending & ~mask.
  - If all pending bits are masked, the FSM stays in IDLE.
  - Changing mask while in PRESENT does not withdraw the presented ID.
- Undefined:
  - No mask port exists.
  - Selection uses pending directly.

Test Plan:
- Reset, then hold req=0 for 5 cycles -> irq_valid=0, pending=0x00, overrun=0 throughout.
- N=8: raise req=0x05 for one edge, hold it high, ack one cycle after each irq_valid -> irq_id=2 then irq_id=0, with one dead cycle between; pending goes 0x05 -> 0x01 -> 0x00.
- Present irq_id=3 and withhold ack 6 cycles while req[7] rises -> irq_id stays 3 and pending=0x88; after ack, the next grant is irq_id=7.
- Pulse req[4] (0->1->0->1) while pending[4]=1 and not being acked -> overrun=1 for exactly one cycle; pending stays 0x10.
- Ack irq_id=4 in the same cycle req[4] rises again -> pending[4] remains 1, overrun=0, and irq_id=4 is re-presented after the dead cycle.
- PRIORITY_IRQ_MASK_EN defined, mask=0x80, pending=0x81 -> irq_id=0 is granted. Then mask=0x00 -> irq_id=7 is presented on the next grant. Separately, assert rst mid-PRESENT -> all outputs 0 asynchronously.
